// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue path: operand width, opcodes, issuer state encoding.
package fpu_pkg;

    localparam int unsigned FPU_W = 64;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_NONE = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd4;
    localparam logic [OP_W-1:0] OP_SQRT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_e;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SQRT);
    endfunction

endpackage

// File: rtl/fpu_wd_timer.sv
// Watchdog for the issuer WAIT state: counts enabled cycles since the last clear and
// raises expired during the TIMEOUT_CYCLES-th enabled cycle.
module fpu_wd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EXP_AT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;

    logic [CNT_W-1:0] r_cnt;
    logic             r_expired;

    // expired is registered one cycle early so it is already high in the final cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_expired <= 1'b0;
        end else if (clear) begin
            r_cnt     <= '0;
            r_expired <= (TIMEOUT_CYCLES == 1);
        end else if (enable && !r_expired) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_expired <= (r_cnt == CNT_W'(EXP_AT));
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/fpu_op_issuer.sv
// Single-outstanding command issuer in front of the FPU ALU FSM.
// Optional WAIT-state watchdog enabled by defining FPU_ISSUER_TIMEOUT_EN.
module fpu_op_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_opcode,
    input  logic [FPU_W-1:0] cmd_a,
    input  logic [FPU_W-1:0] cmd_b,
    output logic [OP_W-1:0]  alu_opcode,
    output logic [FPU_W-1:0] alu_a,
    output logic [FPU_W-1:0] alu_b,
    input  logic [FPU_W-1:0] alu_result,
    input  logic             alu_exception,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [FPU_W-1:0] rsp_result,
    output logic             rsp_exception,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_timeout
);

    issuer_state_e    r_state;
    logic [OP_W-1:0]  r_op;
    logic             r_cmd_ready;
    logic [OP_W-1:0]  r_alu_opcode;
    logic [FPU_W-1:0] r_alu_a;
    logic [FPU_W-1:0] r_alu_b;
    logic             r_rsp_valid;
    logic [FPU_W-1:0] r_rsp_result;
    logic             r_rsp_exception;
    logic             r_rsp_overflow;
    logic             r_rsp_underflow;
    logic             r_rsp_timeout;
    logic             w_tmr_expired;

`ifdef FPU_ISSUER_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_enable;

    assign w_tmr_clear  = (r_state != ST_WAIT);
    assign w_tmr_enable = (r_state == ST_WAIT);

    fpu_wd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_enable),
        .expired (w_tmr_expired)
    );
`else
    // Constant 0 for any legal TIMEOUT_CYCLES: WAIT never gives up in this build.
    assign w_tmr_expired = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_op            <= OP_NONE;
            r_cmd_ready     <= 1'b1;
            r_alu_opcode    <= OP_NONE;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_result    <= '0;
            r_rsp_exception <= 1'b0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
            r_rsp_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_opcode;
                        r_alu_a     <= cmd_a;
                        r_alu_b     <= cmd_b;
                        if (op_is_valid(cmd_opcode)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            // Illegal opcode: answer immediately, ALU never sees it
                            r_state         <= ST_RESP;
                            r_rsp_valid     <= 1'b1;
                            r_rsp_result    <= '0;
                            r_rsp_exception <= 1'b1;
                            r_rsp_overflow  <= 1'b0;
                            r_rsp_underflow <= 1'b0;
                            r_rsp_timeout   <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A done left over from the previous op must drop before issuing
                    if (!alu_done) begin
                        r_state      <= ST_WAIT;
                        r_alu_opcode <= r_op;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_state         <= ST_RESP;
                        r_alu_opcode    <= OP_NONE;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_result    <= alu_result;
                        r_rsp_exception <= alu_exception;
                        r_rsp_overflow  <= alu_overflow  && (r_op == OP_MUL);
                        r_rsp_underflow <= alu_underflow && (r_op == OP_MUL);
                        r_rsp_timeout   <= 1'b0;
                    end else if (w_tmr_expired) begin
                        r_state         <= ST_RESP;
                        r_alu_opcode    <= OP_NONE;
                        r_rsp_valid     <= 1'b1;
                        r_rsp_result    <= '0;
                        r_rsp_exception <= 1'b1;
                        r_rsp_overflow  <= 1'b0;
                        r_rsp_underflow <= 1'b0;
                        r_rsp_timeout   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign alu_opcode    = r_alu_opcode;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_exception = r_rsp_exception;
    assign rsp_overflow  = r_rsp_overflow;
    assign rsp_underflow = r_rsp_underflow;
    assign rsp_timeout   = r_rsp_timeout;

endmodule
